// File: rtl/rptr_empty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rptr_empty_ctrl
// Purpose  : Read-domain pointer and status logic for an asynchronous FIFO.
//            Tracks the binary/Gray read pointer and derives empty,
//            almost-empty, fill-level and sticky-underflow flags from the
//            synchronised Gray write pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rptr_empty_ctrl #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rerr_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE + 1)'(AE_THRESH);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] level_next;
    logic              rd_en;
    logic              uf_set;

    // A read is only honoured when the FIFO is not empty; otherwise it is an
    // underflow attempt and the pointer holds.
    assign rd_en     = rinc & ~rempty;
    assign uf_set    = rinc & rempty;

    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;

    // Gray-to-binary conversion of the synchronised write pointer.
    assign wbin_s[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    generate
        for (genvar i = ADDRSIZE - 1; i >= 0; i--) begin : g_gray2bin
            assign wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
        end
    endgenerate

    // The wrap bit makes level 0 and level 2^ADDRSIZE distinguishable.
    assign level_next = wbin_s - rbinnext;

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            rempty        <= (rgraynext == rq2_wptr);
            rlevel        <= level_next;
            ralmost_empty <= (level_next <= AE_LIMIT);
        end
    end

    // Sticky underflow: a set on the same edge as a clear takes priority.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else if (uf_set) begin
            runderflow <= 1'b1;
        end else if (rerr_clr) begin
            runderflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire
